spi_slave: RTL

SPI responder for the board-side SPI link. It is the far end of `spi_master`: it receives a WIDTH-bit word on `mosi` and returns a WIDTH-bit word on `miso` in the same frame. All pins are oversampled in the `clk` domain; `sclk` is never used as a clock. It sits behind the pin constraints, and its `dout`/`din` side connects to user logic such as display or register banks.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_sync.sv | 32 +++
 rtl/spi_slave.sv | 135 +++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default frame geometry and
// the bit-counter width that spi_master also uses.
package spi_pkg;

    localparam int unsigned SPI_WIDTH = 13;
    localparam int unsigned SPI_SYNC  = 2;
    localparam int unsigned CB_W      = 8;

    typedef enum logic [1:0] {
        WAIT,
        IDLE,
        SHIFT
    } spi_state_t;

    function automatic logic [CB_W-1:0] cb_sat_inc(input logic [CB_W-1:0] v);
        return (v == '1) ? v : v + CB_W'(1);
    endfunction

endpackage

// File: rtl/spi_sync.sv
// N-flop synchronizer with one extra delay flop for rise/fall detection;
// all flops reset to the pin's idle level.
module spi_sync #(
    parameter int unsigned N    = 2,
    parameter logic        IDLE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [N-1:0] chain;
    logic         prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {N{IDLE}};
            prev  <= IDLE;
        end else begin
            chain <= {chain[N-2:0], raw};
            prev  <= chain[N-1];
        end
    end

    assign level = chain[N-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples sclk/load/mosi in the clk domain, receives a
// WIDTH-bit word MSB first and returns din on miso in the same frame.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = SPI_WIDTH,
    parameter int unsigned SYNC  = SPI_SYNC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             load,
    input  logic             mosi,
    output logic             miso,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             frm_err,
    output logic             busy,
    output logic [CB_W-1:0]  cb_bit
);

    logic s_sclk, sclk_rise, sclk_fall;
    logic s_load, load_rise, load_fall;
    logic s_mosi, mosi_rise, mosi_fall;
    logic sync_unused;

    spi_sync #(.N(SYNC), .IDLE(1'b0)) u_sclk (
        .clk   (clk),
        .rst   (rst),
        .raw   (sclk),
        .level (s_sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync #(.N(SYNC), .IDLE(1'b1)) u_load (
        .clk   (clk),
        .rst   (rst),
        .raw   (load),
        .level (s_load),
        .rise  (load_rise),
        .fall  (load_fall)
    );

    spi_sync #(.N(SYNC), .IDLE(1'b0)) u_mosi (
        .clk   (clk),
        .rst   (rst),
        .raw   (mosi),
        .level (s_mosi),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    assign sync_unused = &{s_sclk, mosi_rise, mosi_fall};

    spi_state_t       state;
    logic [WIDTH-1:0] tx_sr;
    logic [WIDTH-1:0] rx_sr;
    logic [7:0]       wait_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WAIT;
            wait_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            cb_bit   <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            frm_err  <= 1'b0;
            busy     <= 1'b0;
            miso     <= 1'b0;
        end else begin
            dout_vld <= 1'b0;
            frm_err  <= 1'b0;
            miso     <= (state == SHIFT) ? tx_sr[WIDTH-1] : 1'b0;

            unique case (state)
                // The synchronizer comes out of reset reporting load=1 even if the
                // pin is low; require SYNC+1 consecutive high samples so that
                // reset-value residue cannot release a frame already in flight.
                WAIT: begin
                    if (s_load) begin
                        if (wait_cnt == 8'(SYNC)) begin
                            state    <= IDLE;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end

                IDLE: begin
                    if (load_fall) begin
                        state  <= SHIFT;
                        busy   <= 1'b1;
                        tx_sr  <= din;
                        rx_sr  <= '0;
                        cb_bit <= '0;
                    end
                end

                SHIFT: begin
                    if (load_rise) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (cb_bit == CB_W'(WIDTH)) begin
                            dout     <= rx_sr;
                            dout_vld <= 1'b1;
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end else begin
                        if (sclk_rise) begin
                            rx_sr  <= {rx_sr[WIDTH-2:0], s_mosi};
                            cb_bit <= cb_sat_inc(cb_bit);
                        end
                        if (sclk_fall) begin
                            tx_sr <= tx_sr << 1;
                        end
                    end
                end

                default: begin
                    state <= WAIT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
